// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one single-port synchronous ROM between a fixed-priority
// video port and a CPU port, with bounded CPU starvation and tagged read return.
`default_nettype none

module rom_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  v_req,
  input  logic [ADDR_WIDTH-1:0] v_addr,
  output logic                  v_ack,
  output logic                  v_valid,
  output logic [DATA_WIDTH-1:0] v_data,

  input  logic                  c_req,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  output logic                  c_ack,
  output logic                  c_valid,
  output logic [DATA_WIDTH-1:0] c_data,

  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       c_force;
  logic       s1_v;
  logic       s1_c;

  // Grant: video has priority unless the CPU has already lost MAX_WAIT times in a row.
  always_comb begin
    c_force = c_req & (wait_cnt == WAIT_LIMIT);
    c_ack   = ~reset & c_req & (~v_req | c_force);
    v_ack   = ~reset & v_req & ~c_ack;
  end

  assign rom_rd   = v_ack | c_ack;
  assign rom_addr = c_ack ? c_addr : v_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 4'd0;
    end else if (c_ack || !c_req) begin
      wait_cnt <= 4'd0;
    end else if (v_ack && (wait_cnt < WAIT_LIMIT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Owner tags travel alongside the read the ROM performs next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      s1_c <= 1'b0;
    end else begin
      s1_v <= v_ack;
      s1_c <= c_ack;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_valid <= 1'b0;
      v_data  <= '0;
    end else begin
      v_valid <= s1_v;
      if (s1_v) begin
        v_data <= rom_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_data  <= '0;
    end else begin
      c_valid <= s1_c;
      if (s1_c) begin
        c_data <= rom_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed checks of rom_arbiter against an attached ROM model.
`default_nettype none

module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v_req = 1'b0;
  logic [11:0] v_addr = '0;
  logic        v_ack;
  logic        v_valid;
  logic [7:0]  v_data;
  logic        c_req = 1'b0;
  logic [11:0] c_addr = '0;
  logic        c_ack;
  logic        c_valid;
  logic [7:0]  c_data;
  logic [11:0] rom_addr;
  logic        rom_rd;
  logic [7:0]  rom_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rom_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_valid(v_valid), .v_data(v_data),
    .c_req(c_req), .c_addr(c_addr), .c_ack(c_ack), .c_valid(c_valid), .c_data(c_data),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data)
  );

  // ROM contents: rom[i] = i[7:0]; output holds when not strobed.
  always @(posedge clk) begin
    if (rom_rd) rom_data <= rom_addr[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, then settle to the falling edge.
  task automatic cyc(input logic rs, input logic vr, input logic [11:0] va,
                     input logic cr, input logic [11:0] ca);
    @(posedge clk);
    #1;
    reset = rs; v_req = vr; v_addr = va; c_req = cr; c_addr = ca;
    @(negedge clk);
  endtask

  logic exp_v [0:7];

  initial begin
    // Reset held with a pending video request: no grant may leak out.
    v_req = 1'b1;
    @(negedge clk);
    check("rst_v_ack", v_ack, 0);
    check("rst_rom_rd", rom_rd, 0);
    check("rst_v_valid", v_valid, 0);
    check("rst_c_data", c_data, 0);

    // Release with no requests.
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("idle_rom_rd", rom_rd, 0);
      check("idle_valids", {v_valid, c_valid}, 0);
      check("idle_data", {v_data, c_data}, 0);
    end

    // CPU alone, three back-to-back reads.
    cyc(0, 0, 0, 1, 12'h000);
    check("cpu0_ack", {v_ack, c_ack}, 2'b01);
    check("cpu0_addr", rom_addr, 12'h000);
    cyc(0, 0, 0, 1, 12'h001);
    check("cpu1_ack", c_ack, 1);
    check("cpu1_addr", rom_addr, 12'h001);
    check("cpu1_valid", c_valid, 0);
    cyc(0, 0, 0, 1, 12'h002);
    check("cpu2_ack", c_ack, 1);
    check("cpu_ret0", {c_valid, c_data}, {1'b1, 8'h00});
    cyc(0, 0, 0, 0, 0);
    check("cpu3_ack", c_ack, 0);
    check("cpu_ret1", {c_valid, c_data}, {1'b1, 8'h01});
    cyc(0, 0, 0, 0, 0);
    check("cpu_ret2", {c_valid, c_data}, {1'b1, 8'h02});
    check("cpu_no_v", v_valid, 0);
    cyc(0, 0, 0, 0, 0);
    check("cpu_hold", {c_valid, c_data}, {1'b0, 8'h02});

    // One simultaneous request: video first, CPU next cycle.
    cyc(0, 1, 12'h010, 1, 12'h020);
    check("sim_v_first", {v_ack, c_ack}, 2'b10);
    check("sim_addr0", rom_addr, 12'h010);
    cyc(0, 0, 0, 1, 12'h020);
    check("sim_c_next", {v_ack, c_ack}, 2'b01);
    check("sim_addr1", rom_addr, 12'h020);
    cyc(0, 0, 0, 0, 0);
    check("sim_v_ret", {v_valid, c_valid, v_data}, {2'b10, 8'h10});
    cyc(0, 0, 0, 0, 0);
    check("sim_c_ret", {v_valid, c_valid, c_data}, {2'b01, 8'h20});

    // Continuous dual requests: V,V,V,C repeating.
    exp_v = '{1, 1, 1, 0, 1, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 12'h030, 1, 12'h040);
      check("dual_grant", {v_ack, c_ack}, {exp_v[i], ~exp_v[i]});
      if (i >= 2) begin
        check("dual_ret", {v_valid, c_valid}, {exp_v[i-2], ~exp_v[i-2]});
        if (exp_v[i-2]) check("dual_vdata", v_data, 8'h30);
        else            check("dual_cdata", c_data, 8'h40);
      end
    end

    // CPU withdraws after two losses; counter restarts.
    cyc(0, 1, 12'h030, 1, 12'h040);
    check("drop_g0", c_ack, 0);
    cyc(0, 1, 12'h030, 1, 12'h040);
    check("drop_g1", c_ack, 0);
    cyc(0, 1, 12'h030, 0, 12'h040);
    check("drop_off", {v_ack, c_ack}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 12'h030, 1, 12'h040);
      check("drop_lose", {v_ack, c_ack}, 2'b10);
    end
    cyc(0, 1, 12'h030, 1, 12'h040);
    check("drop_win", {v_ack, c_ack}, 2'b01);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Reset in the cycle after a video grant drops the in-flight read.
    cyc(0, 1, 12'h055, 0, 0);
    check("rr_ack", v_ack, 1);
    cyc(1, 0, 0, 0, 0);
    check("rr_in_ack", {v_ack, c_ack, rom_rd}, 0);
    check("rr_vdata", v_data, 0);
    cyc(0, 1, 12'h007, 1, 12'h008);
    check("rr_first", {v_ack, c_ack}, 2'b10);
    check("rr_novalid", v_valid, 0);
    cyc(0, 0, 0, 1, 12'h008);
    check("rr_c", c_ack, 1);
    check("rr_novalid2", v_valid, 0);
    check("rr_vdata2", v_data, 0);
    cyc(0, 0, 0, 0, 0);
    check("rr_vret", {v_valid, v_data}, {1'b1, 8'h07});
    cyc(0, 0, 0, 0, 0);
    check("rr_cret", {c_valid, c_data}, {1'b1, 8'h08});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
